// File: rtl/interrupt_priority_arbiter.sv
// Fixed-priority interrupt arbiter: rising-edge request latching, mask and
// global enable gating, INTR/INTA handshake with RST-style vectors, and an
// in-service register that only lets strictly higher priorities nest.
module interrupt_priority_arbiter #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [7:0]  VEC_BASE   = 8'h08,
  parameter logic [7:0]  VEC_STRIDE = 8'h08
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ie,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_din,
  input  logic               inta,
  input  logic               eoi,
  output logic               intr,
  output logic [7:0]         vector,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] mask
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    VEC  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_IRQ-1:0] irq_prev_reg;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [NUM_IRQ-1:0] in_service_reg, in_service_next;
  logic [NUM_IRQ-1:0] mask_reg;
  logic [IDX_W-1:0]   win_idx_reg;
  logic [7:0]         vector_reg;

  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] isr_blocked;
  logic [NUM_IRQ-1:0] eligible;
  logic               any_eligible;
  logic [IDX_W-1:0]   elig_idx;
  logic               ack;
  logic               cancel;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [NUM_IRQ-1:0] eoi_keep;
  logic [7:0]         vec_calc;

  assign irq_rise = irq & ~irq_prev_reg;

  // A source is blocked when it, or anything of higher priority, is in service.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_elig
      assign isr_blocked[gi] = |in_service_reg[gi:0];
      assign eligible[gi]    = pending_reg[gi] & ~mask_reg[gi] & ie & ~isr_blocked[gi];
    end
  endgenerate

  assign any_eligible = |eligible;

  // Lowest eligible index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    elig_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) elig_idx = IDX_W'(i);
    end
  end

  assign ack    = (state_reg == REQ) && inta;
  assign cancel = (state_reg == REQ) && !inta &&
                  (!ie || mask_reg[win_idx_reg] || !pending_reg[win_idx_reg]);

  assign win_onehot = NUM_IRQ'(1) << win_idx_reg;
  assign vec_calc   = VEC_BASE + 8'(win_idx_reg) * VEC_STRIDE;

  // x & (x-1) drops the lowest set bit, i.e. the highest-priority ISR entry.
  assign eoi_keep = eoi ? (in_service_reg & (in_service_reg - NUM_IRQ'(1))) : in_service_reg;

  // Next pending/in-service: a fresh edge wins over an acknowledge clear, and
  // the acknowledge set is applied after the EOI clear.
  always_comb begin
    pending_next    = pending_reg;
    in_service_next = eoi_keep;
    if (ack) begin
      pending_next    = pending_reg & ~win_onehot;
      in_service_next = eoi_keep | win_onehot;
    end
    pending_next = pending_next | irq_rise;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (Rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_eligible) state_next = REQ;
      REQ:     if (ack) state_next = VEC;
               else if (cancel) state_next = IDLE;
      VEC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    intr         = (state_reg == REQ);
    vector_valid = (state_reg == VEC);
  end

  // Datapath registers: edge history, pending, ISR, mask, winner, vector.
  always_ff @(posedge clk) begin
    if (Rst) begin
      irq_prev_reg   <= '0;
      pending_reg    <= '0;
      in_service_reg <= '0;
      mask_reg       <= '1;
      win_idx_reg    <= '0;
      vector_reg     <= 8'h00;
    end else begin
      irq_prev_reg   <= irq;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      if (mask_wr) mask_reg <= mask_din;
      if (state_reg == IDLE && any_eligible) win_idx_reg <= elig_idx;
      if (ack) vector_reg <= vec_calc;
    end
  end

  assign vector     = vector_reg;
  assign pending    = pending_reg;
  assign in_service = in_service_reg;
  assign mask       = mask_reg;

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// Directed bench for interrupt_priority_arbiter: inputs change 1ns after the
// rising edge and outputs are checked at that same point.
`timescale 1ns/1ps
module tb_interrupt_priority_arbiter;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] irq = 4'h0;
  logic       ie = 1'b1;
  logic       mask_wr = 1'b0;
  logic [3:0] mask_din = 4'h0;
  logic       inta = 1'b0;
  logic       eoi = 1'b0;
  logic       intr;
  logic [7:0] vector;
  logic       vector_valid;
  logic [3:0] pending;
  logic [3:0] in_service;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

  interrupt_priority_arbiter dut (
    .clk(clk), .Rst(Rst), .irq(irq), .ie(ie), .mask_wr(mask_wr),
    .mask_din(mask_din), .inta(inta), .eoi(eoi), .intr(intr),
    .vector(vector), .vector_valid(vector_valid), .pending(pending),
    .in_service(in_service), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(); tick();
    checks++;
    if (intr !== 1'b0 || vector !== 8'h00 || vector_valid !== 1'b0 ||
        pending !== 4'h0 || in_service !== 4'h0 || mask !== 4'hF) begin
      errors++;
      $display("FAIL reset: intr=%b vec=%h vv=%b pend=%h isr=%h mask=%h, want 0 00 0 0 0 F",
               intr, vector, vector_valid, pending, in_service, mask);
    end
    Rst = 1'b0;
    mask_wr = 1'b1; mask_din = 4'h0;
    tick();
    mask_wr = 1'b0;
    checks++;
    if (mask !== 4'h0) begin errors++; $display("FAIL mask_load: mask=%h want 0", mask); end
    $display("reset/mask load done");
  endtask

  task automatic test_single();
    irq = 4'h4;
    tick();
    checks++;
    if (pending !== 4'h4 || intr !== 1'b0) begin
      errors++; $display("FAIL edge_pend: pend=%h intr=%b want 4 0", pending, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL edge_intr: intr=%b want 1", intr); end
    inta = 1'b1;
    tick();
    inta = 1'b0;
    checks++;
    if (vector_valid !== 1'b1 || vector !== 8'h18 || in_service !== 4'h4 ||
        pending !== 4'h0 || intr !== 1'b0) begin
      errors++;
      $display("FAIL ack2: vv=%b vec=%h isr=%h pend=%h intr=%b want 1 18 4 0 0",
               vector_valid, vector, in_service, pending, intr);
    end
    tick();
    checks++;
    if (vector_valid !== 1'b0 || vector !== 8'h18) begin
      errors++; $display("FAIL vv_pulse: vv=%b vec=%h want 0 18", vector_valid, vector);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checks++;
    if (in_service !== 4'h0) begin errors++; $display("FAIL eoi1: isr=%h want 0", in_service); end
    $display("single request irq2 -> vector 18 done");
  endtask

  task automatic test_priority();
    irq = 4'hE;          // new edges on 1 and 3, bit 2 still held
    tick();
    checks++;
    if (pending !== 4'hA) begin errors++; $display("FAIL prio_pend: pend=%h want A", pending); end
    tick();
    inta = 1'b1;
    tick();
    inta = 1'b0;
    checks++;
    if (vector !== 8'h10 || vector_valid !== 1'b1 || in_service !== 4'h2 || pending !== 4'h8) begin
      errors++;
      $display("FAIL prio_first: vec=%h vv=%b isr=%h pend=%h want 10 1 2 8",
               vector, vector_valid, in_service, pending);
    end
    tick(); tick();
    checks++;
    if (intr !== 1'b0) begin errors++; $display("FAIL prio_block: intr=%b want 0", intr); end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL prio_second_req: intr=%b want 1", intr); end
    inta = 1'b1;
    tick();
    inta = 1'b0;
    checks++;
    if (vector !== 8'h20 || in_service !== 4'h8 || pending !== 4'h0) begin
      errors++;
      $display("FAIL prio_second: vec=%h isr=%h pend=%h want 20 8 0", vector, in_service, pending);
    end
    tick();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    $display("simultaneous irq1/irq3 -> 10 then 20 done");
  endtask

  task automatic test_nesting();
    irq = 4'h0; tick();
    irq = 4'h4; tick(); tick();
    inta = 1'b1; tick(); inta = 1'b0; tick();
    checks++;
    if (in_service !== 4'h4) begin errors++; $display("FAIL nest_setup: isr=%h want 4", in_service); end
    irq = 4'h5; tick(); tick();
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL nest_preempt: intr=%b want 1", intr); end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if (vector !== 8'h08 || in_service !== 4'h5) begin
      errors++; $display("FAIL nest_ack: vec=%h isr=%h want 08 5", vector, in_service);
    end
    tick();
    irq = 4'hD; tick(); tick();
    checks++;
    if (intr !== 1'b0 || pending !== 4'h8) begin
      errors++; $display("FAIL nest_low_wait: intr=%b pend=%h want 0 8", intr, pending);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if (in_service !== 4'h4) begin errors++; $display("FAIL nest_eoi_a: isr=%h want 4", in_service); end
    tick();
    checks++;
    if (intr !== 1'b0) begin errors++; $display("FAIL nest_still_wait: intr=%b want 0", intr); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++;
    if (intr !== 1'b1 || in_service !== 4'h0) begin
      errors++; $display("FAIL nest_release: intr=%b isr=%h want 1 0", intr, in_service);
    end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if (vector !== 8'h20) begin errors++; $display("FAIL nest_vec3: vec=%h want 20", vector); end
    tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    $display("nesting irq0 over irq2, irq3 waits done");
  endtask

  task automatic test_cancel();
    irq = 4'h0; tick();
    irq = 4'h2; tick(); tick();
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL cancel_pre: intr=%b want 1", intr); end
    ie = 1'b0; tick();
    checks++;
    if (intr !== 1'b0 || pending !== 4'h2) begin
      errors++; $display("FAIL cancel_ie: intr=%b pend=%h want 0 2", intr, pending);
    end
    ie = 1'b1; tick();
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL cancel_restore: intr=%b want 1", intr); end
    inta = 1'b1; tick(); inta = 1'b0; tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if (in_service !== 4'h0 || pending !== 4'h0) begin
      errors++; $display("FAIL cancel_clean: isr=%h pend=%h want 0 0", in_service, pending);
    end
    $display("ie drop cancels and restores request done");
  endtask

  task automatic test_simultaneous();
    irq = 4'h0; tick();
    irq = 4'h2; tick(); tick();
    inta = 1'b1; tick(); inta = 1'b0; tick();   // isr = 2
    irq = 4'h3; tick(); tick();                 // REQ for source 0
    irq = 4'h2; tick();                         // drop irq0 while waiting
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL simul_req: intr=%b want 1", intr); end
    irq = 4'h3; inta = 1'b1; eoi = 1'b1;
    tick();
    inta = 1'b0; eoi = 1'b0;
    checks++;
    if (in_service !== 4'h1 || pending !== 4'h1 || vector !== 8'h08) begin
      errors++;
      $display("FAIL simul_ack_eoi_edge: isr=%h pend=%h vec=%h want 1 1 08",
               in_service, pending, vector);
    end
    tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL simul_kept_edge: intr=%b want 1", intr); end
    inta = 1'b1; tick(); inta = 1'b0; tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    $display("eoi+inta and edge+clear in same cycle done");
  endtask

  task automatic test_reset_in_req();
    irq = 4'h0; tick();
    irq = 4'h1; tick(); tick();
    checks++;
    if (intr !== 1'b1) begin errors++; $display("FAIL rreq_pre: intr=%b want 1", intr); end
    Rst = 1'b1; tick(); Rst = 1'b0;
    checks++;
    if (intr !== 1'b0 || vector !== 8'h00 || pending !== 4'h0 ||
        in_service !== 4'h0 || mask !== 4'hF) begin
      errors++;
      $display("FAIL rreq_reset: intr=%b vec=%h pend=%h isr=%h mask=%h want 0 00 0 0 F",
               intr, vector, pending, in_service, mask);
    end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if (vector_valid !== 1'b0 || vector !== 8'h00) begin
      errors++; $display("FAIL rreq_inta: vv=%b vec=%h want 0 00", vector_valid, vector);
    end
    $display("reset during REQ done");
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_cancel();
    test_simultaneous();
    test_reset_in_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
